// File: rtl/gin_id_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
//  gin_id_scan_ctrl_if : config-loader and X-bus scan-chain signal bundle
//  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface gin_id_scan_ctrl_if #(
  parameter int COL_TAG_WIDTH = 4
);
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [COL_TAG_WIDTH-1:0] cfg_id;
  logic                     start;
  logic                     verify_en;
  logic                     se_id;
  logic                     si_id;
  logic                     so_id;
  logic                     busy;
  logic                     done;
  logic                     err;

  // master = config loader plus X-bus chain; slave = the scan controller
  modport master (
    output cfg_valid, cfg_id, start, verify_en, so_id,
    input  cfg_ready, se_id, si_id, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_id, start, verify_en, so_id,
    output cfg_ready, se_id, si_id, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/gin_id_scan_ctrl.sv
// ---------------------------------------------------------------------------
//  gin_id_scan_ctrl : buffers one tag per X-bus column and shifts them into
//  the MCC ID scan chain, with an optional read-back verify pass.
//  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gin_id_scan_ctrl #(
  parameter int NUM_OF_COLS   = 14,
  parameter int COL_TAG_WIDTH = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  gin_id_scan_ctrl_if.slave   bus
);

  localparam int CHAIN_LEN = NUM_OF_COLS * COL_TAG_WIDTH;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int LOAD_W    = $clog2(NUM_OF_COLS + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [LOAD_W-1:0] NUM_COLS = LOAD_W'(NUM_OF_COLS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                 state;
  logic [LOAD_W-1:0]      load_cnt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CHAIN_LEN-1:0]   chain_buf;
  logic                   verify_q;
  logic                   se_q;
  logic                   si_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic                   load_full;
  logic                   cfg_fire;

  assign load_full     = (load_cnt == NUM_COLS);
  assign bus.cfg_ready = (load_cnt < NUM_COLS) && !busy_q;
  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;

  assign bus.se_id = se_q;
  assign bus.si_id = si_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

  // chain_buf[c*W+b] holds column c bit b, so its MSB is stream bit 0. The
  // buffer is rotated once per presented bit and is back in place after
  // every L-bit pass, which lets the verify pass replay the same stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      load_cnt  <= '0;
      bit_cnt   <= '0;
      chain_buf <= '0;
      verify_q  <= 1'b0;
      se_q      <= 1'b0;
      si_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && load_full) begin
            verify_q  <= bus.verify_en;
            err_q     <= 1'b0;
            bit_cnt   <= '0;
            busy_q    <= 1'b1;
            se_q      <= 1'b1;
            si_q      <= chain_buf[CHAIN_LEN-1];
            chain_buf <= {chain_buf[CHAIN_LEN-2:0], chain_buf[CHAIN_LEN-1]};
            state     <= ST_SHIFT;
          end else if (cfg_fire) begin
            for (int c = 0; c < NUM_OF_COLS; c++) begin
              if (load_cnt == LOAD_W'(c)) begin
                chain_buf[c*COL_TAG_WIDTH +: COL_TAG_WIDTH] <= bus.cfg_id;
              end
            end
            load_cnt <= load_cnt + LOAD_W'(1);
          end
        end

        ST_SHIFT, ST_VERIFY: begin
          // so_id on a verify edge is the bit presented L edges earlier
          if (state == ST_VERIFY && bus.so_id != si_q) begin
            err_q <= 1'b1;
          end
          if (bit_cnt == LAST_BIT) begin
            if (state == ST_SHIFT && verify_q) begin
              bit_cnt   <= '0;
              si_q      <= chain_buf[CHAIN_LEN-1];
              chain_buf <= {chain_buf[CHAIN_LEN-2:0], chain_buf[CHAIN_LEN-1]};
              state     <= ST_VERIFY;
            end else begin
              se_q   <= 1'b0;
              si_q   <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end
          end else begin
            bit_cnt   <= bit_cnt + CNT_W'(1);
            si_q      <= chain_buf[CHAIN_LEN-1];
            chain_buf <= {chain_buf[CHAIN_LEN-2:0], chain_buf[CHAIN_LEN-1]};
          end
        end

        ST_DONE: begin
          done_q   <= 1'b0;
          load_cnt <= '0;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gin_id_scan_ctrl.sv
// ---------------------------------------------------------------------------
//  tb_gin_id_scan_ctrl : directed bench with a 14x4 MCC chain model
//  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gin_id_scan_ctrl;

  localparam int N = 14;
  localparam int W = 4;
  localparam int L = N * W;

  logic clk = 1'b0;
  logic reset;

  gin_id_scan_ctrl_if #(.COL_TAG_WIDTH(W)) bus_if ();

  gin_id_scan_ctrl #(
    .NUM_OF_COLS   (N),
    .COL_TAG_WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  // MCC chain model: col i bit b at chain[i*W+b]; shifts left on se_id
  logic [L-1:0] chain = '0;
  logic         stuck = 1'b0;
  logic [L-1:0] stuck_mask;
  assign stuck_mask   = stuck ? (L'(1) << 7) : '0;
  assign bus_if.so_id = chain[L-1];

  always @(posedge clk) begin
    if (bus_if.se_id) chain <= {chain[L-2:0], bus_if.si_id} & ~stuck_mask;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int se_n;
  int acc;
  logic [3:0] first_bits;
  logic       ready_seen;
  logic       err_at_start;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L-1:0] exp_chain(input int base);
    logic [L-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++) e[i*W +: W] = W'((base + i) % 16);
    return e;
  endfunction

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.cfg_valid = 1'b1;
      bus_if.cfg_id    = W'((base + i) % 16);
      tick();
    end
    bus_if.cfg_valid = 1'b0;
  endtask

  // latency counts edges from the one that samples start to the done cycle
  task automatic run(input logic ver, input int poke_at);
    bus_if.verify_en = ver;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start     = 1'b0;
    bus_if.verify_en = 1'b0;
    err_at_start = bus_if.err;
    lat = 1; se_n = 0; first_bits = '0; ready_seen = 1'b0;
    while (!bus_if.done && lat < 400) begin
      if (bus_if.se_id) begin
        if (se_n < 4) first_bits = {first_bits[2:0], bus_if.si_id};
        se_n++;
      end
      if (bus_if.cfg_ready) ready_seen = 1'b1;
      bus_if.start = (lat == poke_at);
      tick();
      lat++;
    end
    bus_if.start     = 1'b0;
    bus_if.cfg_valid = 1'b0;
    check("done_cycle_busy", bus_if.busy, 0);
    check("done_cycle_se", bus_if.se_id, 0);
    check("done_cycle_ready", bus_if.cfg_ready, 0);
    tick();
    check("done_one_cycle", bus_if.done, 0);
    check("idle_ready", bus_if.cfg_ready, 1);
  endtask

  initial begin
    reset            = 1'b0;
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_id    = '0;
    bus_if.start     = 1'b0;
    bus_if.verify_en = 1'b0;
    repeat (3) tick();
    check("rst_cfg_ready", bus_if.cfg_ready, 1);
    check("rst_se", bus_if.se_id, 0);
    check("rst_si", bus_if.si_id, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_err", bus_if.err, 0);
    reset = 1'b1;
    tick();

    // 1: plain shift of tags 0..13
    load(0, N);
    check("t1_ready_full", bus_if.cfg_ready, 0);
    run(1'b0, -1);
    check("t1_latency", lat, 57);
    check("t1_se_cycles", se_n, 56);
    check("t1_first_bits", first_bits, 4'b1101);
    check("t1_err", bus_if.err, 0);
    check("t1_chain", chain, exp_chain(0));

    // 2: shift plus verify on a healthy chain
    load(0, N);
    run(1'b1, -1);
    check("t2_latency", lat, 113);
    check("t2_se_cycles", se_n, 112);
    check("t2_err", bus_if.err, 0);
    check("t2_chain", chain, exp_chain(0));

    // 3: chain bit 7 stuck at 0 makes verify flag err, which stays set
    stuck = 1'b1;
    load(0, N);
    run(1'b1, -1);
    check("t3_latency", lat, 113);
    check("t3_err_set", bus_if.err, 1);
    tick();
    check("t3_err_sticky", bus_if.err, 1);
    stuck = 1'b0;

    // 4: start with a partial load is ignored and leaves err alone
    load(0, 5);
    check("t4_ready_partial", bus_if.cfg_ready, 1);
    bus_if.start     = 1'b1;
    bus_if.verify_en = 1'b1;
    tick();
    bus_if.start     = 1'b0;
    bus_if.verify_en = 1'b0;
    check("t4_ign_busy", bus_if.busy, 0);
    check("t4_ign_se", bus_if.se_id, 0);
    check("t4_ign_ready", bus_if.cfg_ready, 1);
    check("t4_ign_err", bus_if.err, 1);
    tick();
    check("t4_ign_busy2", bus_if.busy, 0);
    load(5, N - 5);
    check("t4_ready_full", bus_if.cfg_ready, 0);
    run(1'b0, -1);
    check("t4_err_cleared", err_at_start, 0);
    check("t4_latency", lat, 57);
    check("t4_err_end", bus_if.err, 0);
    check("t4_chain", chain, exp_chain(0));

    // 5: 20 back-to-back beats, only 14 taken; start during busy ignored
    acc = 0;
    bus_if.cfg_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_if.cfg_id = W'((3 + i) % 16);
      if (bus_if.cfg_ready) acc++;
      tick();
    end
    check("t5_accepted", acc, 14);
    check("t5_ready_full", bus_if.cfg_ready, 0);
    run(1'b1, 10);
    check("t5_ready_during_busy", ready_seen, 0);
    check("t5_latency", lat, 113);
    check("t5_err", bus_if.err, 0);
    check("t5_chain", chain, exp_chain(3));

    // 6: reset in shift cycle 30 aborts immediately
    load(0, N);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (29) tick();
    check("t6_pre_busy", bus_if.busy, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_se", bus_if.se_id, 0);
    check("t6_rst_busy", bus_if.busy, 0);
    check("t6_rst_ready", bus_if.cfg_ready, 1);
    tick();
    reset = 1'b1;
    tick();
    check("t6_rel_ready", bus_if.cfg_ready, 1);
    check("t6_rel_se", bus_if.se_id, 0);
    load(0, N - 1);
    check("t6_cnt13_ready", bus_if.cfg_ready, 1);
    load(N - 1, 1);
    check("t6_cnt14_ready", bus_if.cfg_ready, 0);
    run(1'b0, -1);
    check("t6_latency", lat, 57);
    check("t6_chain", chain, exp_chain(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
